// File: rtl/ring_pkg.sv
// Shared types and helpers for consumers of the one-hot ring counter.
// Lock FSM states, default ring geometry and the legal-advance rotation.
package ring_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } mon_state_t;

    localparam int RING_WIDTH    = 4;
    localparam int RING_LOCK_CNT = 2;
    localparam int RING_MAX_W    = 64;

    // Right-rotate the low `width` bits of a zero-extended vector; bits above
    // width-1 come back as zero so callers can compare full-width values.
    function automatic logic [RING_MAX_W-1:0] rot_next(
        input logic [RING_MAX_W-1:0] vec,
        input int                    width
    );
        logic [RING_MAX_W-1:0] r;
        r = vec >> 1;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (i == width - 1) r[i] = vec[0];
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_encode.sv
// Combinational one-hot checker and binary encoder for a ring phase vector.
// Unknown or multi-hot inputs report is_onehot = 0.
module onehot_encode #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_onehot,
    output logic [IW-1:0]    idx
);

    logic seen;
    logic multi;

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
                idx  = IW'(i);
            end
        end
        is_onehot = seen & ~multi;
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring's phase sequence, tracks lock, counts revolutions
// and logs faults; exposes a registered slot index for downstream logic.
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = RING_WIDTH,
    parameter int LOCK_CNT = RING_LOCK_CNT,
    parameter int IW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] phase,
    input  logic             clear_err,
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [15:0]      rev_count,
    output logic             rev_pulse
);

    localparam logic [3:0]       LOCK_V = 4'(LOCK_CNT);
    localparam logic [WIDTH-1:0] SLOT0  = WIDTH'(1);

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       adv_cnt_q, adv_cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [15:0]      rev_count_q, rev_count_d;
    logic             rev_pulse_q, rev_pulse_d;

    logic                  ph_onehot;
    logic [IW-1:0]         enc_idx;
    logic [RING_MAX_W-1:0] ext_prev, ext_phase, exp_next;
    logic                  hold, advance, fault, rev;

    onehot_encode #(.WIDTH(WIDTH), .IW(IW)) u_enc (
        .vec       (phase),
        .is_onehot (ph_onehot),
        .idx       (enc_idx)
    );

    // Comparisons are made at full helper width; the zero upper bits match.
    always_comb begin
        ext_prev                = '0;
        ext_phase               = '0;
        ext_prev[WIDTH-1:0]     = prev_q;
        ext_phase[WIDTH-1:0]    = phase;
        exp_next                = rot_next(ext_prev, WIDTH);
        hold                    = ph_onehot && (ext_phase == ext_prev);
        advance                 = ph_onehot && (ext_phase == exp_next);
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        adv_cnt_d = adv_cnt_q;
        fault     = 1'b0;
        rev       = 1'b0;
        unique case (state_q)
            UNLOCKED: begin
                if (ph_onehot) begin
                    prev_d    = phase;
                    adv_cnt_d = '0;
                    state_d   = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (advance) begin
                    prev_d    = phase;
                    adv_cnt_d = adv_cnt_q + 4'd1;
                    if (adv_cnt_d == LOCK_V) state_d = LOCKED;
                end else if (!hold) begin
                    state_d = UNLOCKED;
                end
            end
            LOCKED: begin
                if (advance) begin
                    prev_d = phase;
                    rev    = (phase == SLOT0);
                end else if (!hold) begin
                    fault   = 1'b1;
                    state_d = FAULT;
                end
            end
            FAULT:   state_d = UNLOCKED;
            default: state_d = UNLOCKED;
        endcase
    end

    // A fault in the same cycle as clear_err keeps the flag set.
    always_comb begin
        idx_d       = ph_onehot ? enc_idx : idx_q;
        idx_valid_d = ph_onehot;
        locked_d    = (state_d == LOCKED);
        rev_pulse_d = rev;
        rev_count_d = rev_count_q + 16'(rev);
        err_d       = fault ? 1'b1 : (clear_err ? 1'b0 : err_q);
        err_count_d = (fault && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            prev_q      <= '0;
            adv_cnt_q   <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            rev_count_q <= '0;
            rev_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            adv_cnt_q   <= adv_cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            rev_count_q <= rev_count_d;
            rev_pulse_q <= rev_pulse_d;
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign rev_count = rev_count_q;
    assign rev_pulse = rev_pulse_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Randomized and directed bench for ring_phase_monitor against a slot-index
// reference model, plus literal checkpoints from hand-worked sequences.
module tb_ring_phase_monitor;

    localparam int W  = 4;
    localparam int LK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_err;
    logic [W-1:0] phase;
    logic [1:0]  idx;
    logic        idx_valid, locked, err, rev_pulse;
    logic [7:0]  err_count;
    logic [15:0] rev_count;

    ring_phase_monitor #(.WIDTH(W), .LOCK_CNT(LK)) dut (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .clear_err (clear_err),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .rev_count (rev_count),
        .rev_pulse (rev_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en  = 1'b0;
    bit preload = 1'b0;

    // Reference model: tracks the slot index last accepted, and a mode
    // 0 = searching, 1 = acquiring, 2 = locked, 3 = recovering from a fault.
    int          m_mode = 0, m_ref = 0, m_acq = 0, m_idx = 0;
    bit          m_vld = 0, m_err = 0, m_pulse = 0;
    int          m_ecnt = 0;
    logic [15:0] m_rev = '0;

    always @(posedge clk) begin
        bit oh, flt;
        int s;
        oh = !$isunknown(phase) && ($countones(phase) == 1);
        s  = 0;
        for (int i = 0; i < W; i++) if (phase[i] === 1'b1) s = i;
        if (rst) begin
            m_mode = 0; m_ref = 0; m_acq = 0; m_idx = 0; m_vld = 0;
            m_err = 0; m_ecnt = 0; m_rev = '0; m_pulse = 0;
        end else begin
            flt = 0;
            m_pulse = 0;
            if (oh) m_idx = s;
            m_vld = oh;
            case (m_mode)
                0: if (oh) begin m_ref = s; m_acq = 0; m_mode = 1; end
                1: begin
                    if (oh && s == m_ref) begin end
                    else if (oh && s == (m_ref + W - 1) % W) begin
                        m_ref = s; m_acq++;
                        if (m_acq == LK) m_mode = 2;
                    end else m_mode = 0;
                end
                2: begin
                    if (oh && s == m_ref) begin end
                    else if (oh && s == (m_ref + W - 1) % W) begin
                        m_ref = s;
                        if (s == 0) begin m_rev = m_rev + 16'd1; m_pulse = 1; end
                    end else begin flt = 1; m_mode = 3; end
                end
                default: m_mode = 0;
            endcase
            if (flt) begin
                m_err = 1;
                if (m_ecnt < 255) m_ecnt++;
            end else if (clear_err) m_err = 0;
            if (preload) m_rev = 16'hFFFE;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            chk("m_idx",       32'(idx),       32'(m_idx));
            chk("m_idx_valid", 32'(idx_valid), 32'(m_vld));
            chk("m_locked",    32'(locked),    32'(m_mode == 2));
            chk("m_err",       32'(err),       32'(m_err));
            chk("m_err_count", 32'(err_count), 32'(m_ecnt));
            chk("m_rev_count", 32'(rev_count), 32'(m_rev));
            chk("m_rev_pulse", 32'(rev_pulse), 32'(m_pulse));
            if (rev_pulse && !locked) chk("pulse_while_unlocked", 32'(rev_pulse), 32'd0);
        end
    end

    task automatic drive(input logic [W-1:0] p, input bit c = 1'b0);
        phase = p;
        clear_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_idx"},  32'(idx), 0);
        chk({nm, "_vld"},  32'(idx_valid), 0);
        chk({nm, "_lock"}, 32'(locked), 0);
        chk({nm, "_err"},  32'(err), 0);
        chk({nm, "_ecnt"}, 32'(err_count), 0);
        chk({nm, "_rev"},  32'(rev_count), 0);
        chk({nm, "_pls"},  32'(rev_pulse), 0);
    endtask

    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] p;
        int r;
        rst = 1'b1; clear_err = 1'b0; phase = 'x;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Acquire: hold does not count, lock on second advance.
        drive(4'b0001); chk("acq0_lock", 32'(locked), 0); chk("acq0_idx", 32'(idx), 0);
        drive(4'b0001); chk("acq_hold_lock", 32'(locked), 0);
        drive(4'b1000); chk("acq1_idx", 32'(idx), 3); chk("acq1_lock", 32'(locked), 0);
        drive(4'b0100); chk("acq2_idx", 32'(idx), 2); chk("acq2_lock", 32'(locked), 1);

        // Revolutions.
        drive(4'b0010);
        drive(4'b0001); chk("rev1_pulse", 32'(rev_pulse), 1); chk("rev1_cnt", 32'(rev_count), 1);
        drive(4'b1000); chk("rev1_pulse_off", 32'(rev_pulse), 0);
        drive(4'b0100);
        drive(4'b0010);
        drive(4'b0001); chk("rev2_pulse", 32'(rev_pulse), 1); chk("rev2_cnt", 32'(rev_count), 2);

        // Non-one-hot fault, then a wrong-step fault.
        drive(4'b0110);
        chk("f1_vld", 32'(idx_valid), 0); chk("f1_err", 32'(err), 1);
        chk("f1_ecnt", 32'(err_count), 1); chk("f1_lock", 32'(locked), 0);
        drive(4'b0001); chk("f1_recov_lock", 32'(locked), 0);
        drive(4'b0001); drive(4'b1000);
        drive(4'b0100); chk("relock1", 32'(locked), 1);
        drive(4'b0010); drive(4'b0001);
        drive(4'b0100); chk("f2_ecnt", 32'(err_count), 2); chk("f2_lock", 32'(locked), 0);

        // clear_err racing a fault, then alone.
        drive(4'b0001); drive(4'b0001); drive(4'b1000);
        drive(4'b0100); chk("relock2", 32'(locked), 1);
        drive(4'b0000, 1'b1); chk("clr_race_err", 32'(err), 1); chk("clr_race_ecnt", 32'(err_count), 3);
        drive(4'b0001, 1'b1); chk("clr_err", 32'(err), 0); chk("clr_ecnt", 32'(err_count), 3);

        // Saturation of the fault counter.
        for (int i = 0; i < 256; i++) begin
            drive(4'b0001); drive(4'b1000); drive(4'b0100);
            drive(4'b0000); drive(4'b0000);
        end
        chk("ecnt_sat", 32'(err_count), 255);

        // Randomized stream: mostly legal, with holds, junk, jumps and resets.
        cur = 4'b0001;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(99));
            if (r < 70)      begin cur = {cur[0], cur[W-1:1]}; p = cur; end
            else if (r < 82) p = cur;
            else if (r < 92) p = W'($urandom_range(15));
            else             begin cur = W'(1 << $urandom_range(W - 1)); p = cur; end
            rst = ($urandom_range(199) == 0);
            drive(p, $urandom_range(7) == 0);
        end
        rst = 1'b0;

        // Reset while locked with five revolutions recorded.
        rst = 1'b1; drive(4'b0001); rst = 1'b0;
        drive(4'b0001); drive(4'b1000); drive(4'b0100);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010); drive(4'b0001); drive(4'b1000); drive(4'b0100);
        end
        chk("rev5", 32'(rev_count), 5); chk("rev5_lock", 32'(locked), 1);
        rst = 1'b1; drive(4'b0010); rst = 1'b0;
        chk_all_zero("midrst");
        drive(4'b1000); chk("rl_a", 32'(locked), 0);
        drive(4'b0100); chk("rl_b", 32'(locked), 0);
        drive(4'b0010); chk("rl_c", 32'(locked), 1);

        // Preload the revolution count and run it through the wrap.
        chk_en = 1'b0;
        force dut.rev_count_q = 16'hFFFE;
        preload = 1'b1;
        drive(4'b0010);
        release dut.rev_count_q;
        preload = 1'b0;
        chk_en = 1'b1;
        chk("preload", 32'(rev_count), 32'hFFFE);
        drive(4'b0001); chk("wrap_ffff", 32'(rev_count), 32'hFFFF);
        drive(4'b1000); drive(4'b0100); drive(4'b0010);
        drive(4'b0001); chk("wrap_zero", 32'(rev_count), 0); chk("wrap_pulse", 32'(rev_pulse), 1);
        drive(4'b0001);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
